video_out_stage: RTL and testbench
==================================

Name: video_out_stage

Overview:
- Parametrised registered video output stage for Verilator/ImGui sim tops and FPGA wrappers.
- Converts a core's packed low-depth RGB plus sync and blank signals into OUT_BITS-per-channel VGA with selectable sync polarity and a DE signal.
- Adds active-area x/y position counters, a per-frame geometry measurement (active pixels per line, active lines per frame) and a frame-done pulse, so the host can lock frame capture.
- Generalises the fixed 3-bit-per-channel replicate-and-invert wrapper used by current cores.

Parameters:
- IN_BITS, 3, bits per input colour channel (1..8).
- OUT_BITS, 8, bits per output colour channel (must be >= IN_BITS).
- ORDER, 0, packing of rgb_i. 0 = {B,G,R} with R in the LSBs. 1 = {R,G,B} with R in the MSBs.
- HS_INV, 1, when 1, vga_hs = ~hsync_i; when 0, vga_hs = hsync_i.
- VS_INV, 1, same as HS_INV, applied to vga_vs.
- XW, 10, width of x_o and line_len_o.
- YW, 10, width of y_o and line_cnt_o.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ce_pix  in  1  pixel clock enable; all pixel-domain state advances only when ce_pix=1.
- rgb_i  in  3*IN_BITS  packed colour from the core.
- hsync_i  in  1  core horizontal sync, active high.
- vsync_i  in  1  core vertical sync, active high.
- hblank_i  in  1  core horizontal blank.
- vblank_i  in  1  core vertical blank.
- vga_r  out  OUT_BITS  expanded red.
- vga_g  out  OUT_BITS  expanded green.
- vga_b  out  OUT_BITS  expanded blue.
- vga_hs  out  1  horizontal sync after polarity selection.
- vga_vs  out  1  vertical sync after polarity selection.
- vga_de  out  1  data enable, = ~(hblank_i|vblank_i), registered.
- x_o  out  XW  index of the current pixel within the active line.
- y_o  out  YW  index of the current active line.
- frame_o  out  1  one-clk_sys pulse at the start of vertical blank.
- line_len_o  out  XW  active pixels counted in the most recent completed line.
- line_cnt_o  out  YW  active lines counted in the most recent completed frame.

Behaviour:
- Reset (synchronous, on a clk_sys edge with reset=1):
  - vga_r/g/b, vga_de, x_o, y_o, frame_o, line_len_o, line_cnt_o = 0.
  - vga_hs = HS_INV, vga_vs = VS_INV (the idle level for an input sync of 0).
  - Previous-de and previous-vblank history registers = 0.
  - Reset takes priority over ce_pix. Asserting reset mid-frame discards partial counts; the first frame_o after reset comes from the next vblank rising edge.
- Latency: one registered stage. On a clk_sys edge with ce_pix=1, all video outputs take values computed from the inputs sampled at that edge. All video outputs are mutually aligned. With ce_pix=0, every output holds, except frame_o, which is forced to 0.
- Colour expansion, per channel: repeat the IN_BITS value MSB-first until OUT_BITS bits are filled, then truncate the LSBs.
  - Example (IN_BITS=3): {c,c,c[2:1]}.
  - If IN_BITS == OUT_BITS, the channel passes through unchanged.
- Blanking: if hblank_i|vblank_i, then vga_r/g/b = 0 and vga_de = 0. Syncs pass through regardless of blanking.
- x counter, on each ce_pix cycle:
  - de=1: x increments, saturating at all-ones.
  - de 1->0 (end of line): line_len_o <= number of active pixels in that line, saturated; x <= 0.
  - x_o shows the pre-increment x, so the first active pixel reports x_o=0.
- y counter:
  - Increments (saturating) at each end of line.
  - On the ce_pix cycle where vblank rises 0->1: line_cnt_o <= y count, y <= 0, frame_o = 1 for exactly that one clk_sys cycle.
  - If end of line and vblank rise occur on the same ce cycle, the line is counted first, so line_cnt_o includes it.
- A vblank that starts mid-line also terminates that line: line_len_o is updated and x is cleared.

Optional Feature:
- Macro: SCANLINE_EN.
- Defined: on active lines where y_o[0]=1, each expanded channel is shifted right by 1 (50% intensity) before registering. Latency is unchanged; blanking still forces 0.
- Undefined: no intensity modification; no extra logic is synthesised.

Test Plan:
- Expansion: IN_BITS=3, ORDER=0, rgb_i=9'b111_000_101 with de=1, one ce_pix pulse -> vga_r=8'hB6, vga_g=8'h00, vga_b=8'hFF on the following cycle.
- Blank and sync: hblank_i=1, rgb_i all ones, hsync_i=1, HS_INV=1 -> vga_r/g/b=0, vga_de=0, vga_hs=0. Set hsync_i=0 -> vga_hs=1.
- Geometry: drive ce_pix every 2nd clk_sys; 240 lines of 320 active pixels, then vblank -> line_len_o=320, line_cnt_o=240. frame_o is high for exactly 1 clk_sys cycle. x_o spans 0..319.
- Enable hold: hold ce_pix=0 for 10 cycles mid-line while changing rgb_i -> all outputs stable, x_o unchanged, frame_o=0.
- Reset mid-frame: assert reset at line 100 for 1 cycle -> all outputs at reset values next cycle. The next complete frame reports the correct line_cnt_o.
- SCANLINE_EN defined: rgb_i=9'h1FF on line 1 -> each channel = 8'h7F; on line 0 -> 8'hFF.

Source files
------------

// File: rtl/video_out_stage.sv
// video_out_stage: registered RGB expansion, sync polarity, DE, active-area x/y counters, frame geometry and frame-done pulse
// Ports: clk_sys/reset (sync, active high), ce_pix pixel enable; rgb_i/hsync_i/vsync_i/hblank_i/vblank_i from the core;
// vga_r/g/b/hs/vs/de to the display; x_o/y_o position; frame_o start-of-vblank pulse; line_len_o/line_cnt_o measured geometry.
// Optional SCANLINE_EN macro halves colour intensity on odd active lines.
module video_out_stage #(
  parameter int IN_BITS  = 3,
  parameter int OUT_BITS = 8,
  parameter bit ORDER    = 1'b0,
  parameter bit HS_INV   = 1'b1,
  parameter bit VS_INV   = 1'b1,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ce_pix,
  input  logic [3*IN_BITS-1:0] rgb_i,
  input  logic                 hsync_i,
  input  logic                 vsync_i,
  input  logic                 hblank_i,
  input  logic                 vblank_i,
  output logic [OUT_BITS-1:0]  vga_r,
  output logic [OUT_BITS-1:0]  vga_g,
  output logic [OUT_BITS-1:0]  vga_b,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_de,
  output logic [XW-1:0]        x_o,
  output logic [YW-1:0]        y_o,
  output logic                 frame_o,
  output logic [XW-1:0]        line_len_o,
  output logic [YW-1:0]        line_cnt_o
);
  logic [IN_BITS-1:0] r_in, g_in, b_in;
  logic [OUT_BITS-1:0] r_e, g_e, b_e, r_s, g_s, b_s;
  logic [XW-1:0] x, x_inc;
  logic [YW-1:0] y, y_inc, y_eol;
  logic prev_de, prev_vb, de, eol, vb_rise;
  assign r_in = ORDER ? rgb_i[3*IN_BITS-1 -: IN_BITS] : rgb_i[IN_BITS-1:0];
  assign g_in = rgb_i[2*IN_BITS-1 -: IN_BITS];
  assign b_in = ORDER ? rgb_i[IN_BITS-1:0] : rgb_i[3*IN_BITS-1 -: IN_BITS];
  // Repeat the input MSB-first across the output width; excess LSBs fall off.
  for (genvar k = 0; k < OUT_BITS; k++) begin : g_exp
    assign r_e[OUT_BITS-1-k] = r_in[IN_BITS-1-(k%IN_BITS)];
    assign g_e[OUT_BITS-1-k] = g_in[IN_BITS-1-(k%IN_BITS)];
    assign b_e[OUT_BITS-1-k] = b_in[IN_BITS-1-(k%IN_BITS)];
  end
`ifdef SCANLINE_EN
  // y is the line index that y_o will show alongside this pixel.
  assign r_s = y[0] ? r_e >> 1 : r_e;
  assign g_s = y[0] ? g_e >> 1 : g_e;
  assign b_s = y[0] ? b_e >> 1 : b_e;
`else
  assign r_s = r_e;
  assign g_s = g_e;
  assign b_s = b_e;
`endif
  assign de      = ~(hblank_i | vblank_i);
  assign eol     = prev_de & ~de;
  assign vb_rise = vblank_i & ~prev_vb;
  assign x_inc   = &x ? x : x + 1'b1;
  assign y_inc   = &y ? y : y + 1'b1;
  // A line ending on the vblank edge is counted before the frame total is latched.
  assign y_eol   = eol ? y_inc : y;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vga_r      <= '0;
      vga_g      <= '0;
      vga_b      <= '0;
      vga_hs     <= HS_INV;
      vga_vs     <= VS_INV;
      vga_de     <= 1'b0;
      x_o        <= '0;
      y_o        <= '0;
      frame_o    <= 1'b0;
      line_len_o <= '0;
      line_cnt_o <= '0;
      x          <= '0;
      y          <= '0;
      prev_de    <= 1'b0;
      prev_vb    <= 1'b0;
    end else begin
      frame_o <= ce_pix & vb_rise;
      if (ce_pix) begin
        vga_r   <= de ? r_s : '0;
        vga_g   <= de ? g_s : '0;
        vga_b   <= de ? b_s : '0;
        vga_hs  <= hsync_i ^ HS_INV;
        vga_vs  <= vsync_i ^ VS_INV;
        vga_de  <= de;
        x_o     <= x;
        y_o     <= y;
        x       <= de ? x_inc : '0;
        y       <= vb_rise ? '0 : y_eol;
        prev_de <= de;
        prev_vb <= vblank_i;
        if (eol) line_len_o <= x;
        if (vb_rise) line_cnt_o <= y_eol;
      end
    end
  end
endmodule

// File: tb/tb_video_out_stage.sv
// tb_video_out_stage: directed stimulus with a tagged expectation queue checked by an independent monitor
`timescale 1ns/1ps
module tb_video_out_stage;
  logic clk_sys = 1'b0, reset = 1'b0, ce_pix = 1'b0;
  logic [8:0] rgb_i = '0;
  logic hsync_i = 1'b0, vsync_i = 1'b0, hblank_i = 1'b1, vblank_i = 1'b0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, vga_de, frame_o;
  logic [9:0] x_o, y_o, line_len_o, line_cnt_o;
  video_out_stage dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .rgb_i(rgb_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .hblank_i(hblank_i), .vblank_i(vblank_i),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_de(vga_de), .x_o(x_o), .y_o(y_o), .frame_o(frame_o),
    .line_len_o(line_len_o), .line_cnt_o(line_cnt_o)
  );
  always #5 clk_sys = ~clk_sys;
  typedef struct {int tag; int sel; logic [31:0] val; string nm;} exp_t;
  localparam int R = 0, G = 1, B = 2, HS = 3, VS = 4, DE = 5, X = 6, Y = 7, FR = 8, LL = 9, LC = 10;
  string fname [11] = '{"vga_r", "vga_g", "vga_b", "vga_hs", "vga_vs", "vga_de", "x_o", "y_o", "frame_o", "line_len_o", "line_cnt_o"};
  exp_t q[$];
  int sn = 0, cur_sn = 0, n_chk = 0, n_fail = 0, frames = 0;
  logic last_fr = 1'b0;
  function automatic logic [31:0] act(input int s);
    case (s)
      R:  return {24'd0, vga_r};
      G:  return {24'd0, vga_g};
      B:  return {24'd0, vga_b};
      HS: return {31'd0, vga_hs};
      VS: return {31'd0, vga_vs};
      DE: return {31'd0, vga_de};
      X:  return {22'd0, x_o};
      Y:  return {22'd0, y_o};
      FR: return {31'd0, frame_o};
      LL: return {22'd0, line_len_o};
      default: return {22'd0, line_cnt_o};
    endcase
  endfunction
  function automatic logic [31:0] col(input int ch, input int yc, input int x);
    logic [7:0] v;
    v = x == 0 ? 8'hFF : ch == 0 ? 8'h24 : ch == 1 ? 8'h49 : 8'h6D;
`ifdef SCANLINE_EN
    if (yc % 2 == 1) v = v >> 1;
`endif
    return {24'd0, v};
  endfunction
  task automatic ex(input int s, input logic [31:0] v, input string nm);
    q.push_back('{sn, s, v, nm});
  endtask
  task automatic drive(input bit c, input logic [8:0] rgb, input bit hs, input bit vs, input bit hb, input bit vb);
    @(negedge clk_sys);
    reset = 1'b0; ce_pix = c; rgb_i = rgb;
    hsync_i = hs; vsync_i = vs; hblank_i = hb; vblank_i = vb;
    sn++; cur_sn = sn;
  endtask
  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1; ce_pix = 1'b1; rgb_i = '1;
    hsync_i = 1'b1; vsync_i = 1'b1; hblank_i = 1'b0; vblank_i = 1'b0;
    sn++; cur_sn = sn;
    for (int s = 0; s < 11; s++) ex(s, (s == HS || s == VS) ? 1 : 0, "reset");
  endtask
  task automatic frame(input int rst_at, input bit direct_vb);
    int yc, len;
    yc = 0;
    for (int y = 0; y < 240; y++) begin
      len = (y < 2 || y == 239) ? 320 : 8;
      if (y == rst_at) begin
        do_reset();
        yc = 0;
      end
      for (int x = 0; x < len; x++) begin
        drive(1, x == 0 ? 9'h1FF : 9'h0D1, 0, 0, 0, 0);
        ex(X, x, "pix"); ex(Y, yc, "pix"); ex(DE, 1, "pix");
        ex(R, col(0, yc, x), "pix"); ex(G, col(1, yc, x), "pix"); ex(B, col(2, yc, x), "pix");
        if (y == 5 && x == 4)
          for (int h = 0; h < 10; h++) begin
            drive(0, 9'($urandom), 0, 0, 0, 0);
            ex(X, 4, "hold"); ex(Y, yc, "hold"); ex(DE, 1, "hold"); ex(FR, 0, "hold");
            ex(R, col(0, yc, 4), "hold"); ex(G, col(1, yc, 4), "hold"); ex(B, col(2, yc, 4), "hold");
          end
        drive(0, 9'h0D1, 0, 0, 0, 0);
      end
      if (!(direct_vb && y == 239)) begin
        drive(1, 9'h1FF, 1, 0, 1, 0);
        ex(LL, len, "eol"); ex(DE, 0, "eol"); ex(R, 0, "eol"); ex(HS, 0, "eol");
        drive(0, 9'h1FF, 0, 0, 1, 0);
      end
      yc++;
    end
    drive(1, 9'h1FF, 0, 1, 1, 1);
    ex(FR, 1, "vbl"); ex(LC, yc, "vbl"); ex(LL, 320, "vbl"); ex(VS, 0, "vbl"); ex(B, 0, "vbl");
    drive(0, 9'h1FF, 0, 1, 1, 1);
    ex(FR, 0, "vbl_next"); ex(LC, yc, "vbl_next");
    drive(1, 9'h1FF, 0, 0, 1, 1);
    ex(FR, 0, "vbl_mid"); ex(Y, 0, "vbl_mid"); ex(VS, 1, "vbl_mid");
    drive(0, 9'h1FF, 0, 0, 1, 1);
  endtask
  always @(posedge clk_sys) begin
    int t;
    exp_t e;
    t = cur_sn;
    #1;
    while (q.size() > 0 && q[0].tag <= t) begin
      e = q.pop_front();
      n_chk++;
      if (act(e.sel) !== e.val) begin
        n_fail++;
        $display("FAIL %s.%s step %0d: got %0h, want %0h", e.nm, fname[e.sel], e.tag, act(e.sel), e.val);
      end
    end
    if (frame_o) frames++;
    if (last_fr) begin
      n_chk++;
      if (frame_o) begin
        n_fail++;
        $display("FAIL frame_width: frame_o got 1 on second cycle, want 0");
      end
    end
    last_fr = frame_o;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    do_reset();
    drive(1, 9'b111_000_101, 0, 0, 0, 0);
    ex(R, 'hB6, "expand"); ex(G, 'h00, "expand"); ex(B, 'hFF, "expand");
    ex(DE, 1, "expand"); ex(HS, 1, "expand"); ex(VS, 1, "expand"); ex(X, 0, "expand"); ex(Y, 0, "expand");
    drive(1, 9'h1FF, 1, 0, 1, 0);
    ex(R, 0, "blank"); ex(G, 0, "blank"); ex(B, 0, "blank"); ex(DE, 0, "blank"); ex(HS, 0, "blank"); ex(LL, 1, "blank");
    drive(1, 9'h1FF, 0, 0, 1, 0);
    ex(HS, 1, "hs_idle");
    drive(1, 9'h1FF, 0, 1, 1, 0);
    ex(VS, 0, "vs_act"); ex(FR, 0, "vs_act");
    drive(0, 9'h1FF, 1, 0, 1, 0);
    ex(HS, 1, "ce_hold"); ex(VS, 0, "ce_hold");
    do_reset();
    frame(-1, 1'b0);
    frame(100, 1'b1);
    frame(-1, 1'b0);
    repeat (3) drive(0, 9'h0, 0, 0, 1, 0);
    n_chk++;
    if (frames != 3) begin
      n_fail++;
      $display("FAIL frame_count: got %0d, want 3", frames);
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
